// File: rtl/axi_mem_pkg.sv
// rtl/axi_mem_pkg.sv - shared types and sizing helpers for the AXI memory responder
package axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  localparam int BEAT_CNT_WIDTH = 4;

  // Latency counter width for a given READ_LATENCY; never narrower than one bit.
  function automatic int lat_cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// rtl/axi_mem_array.sv - word array with one synchronous write port and one asynchronous read port
module axi_mem_array #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH_LOG2 = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI-style memory slave with independent read and write burst engines
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH   = 26,
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH_LOG2   = 14,
  parameter int    READ_LATENCY = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  protocol_error
);

  localparam int LAT_CNT_WIDTH = lat_cnt_width(READ_LATENCY);

  w_state_t                  w_state_q, w_state_d;
  logic [3:0]                awid_q, awid_d;
  logic [BEAT_CNT_WIDTH-1:0] awlen_q, awlen_d;
  logic [BEAT_CNT_WIDTH-1:0] w_cnt_q, w_cnt_d;
  logic [DEPTH_LOG2-1:0]     w_base_q, w_base_d;
  logic                      perr_q, perr_d;

  r_state_t                  r_state_q, r_state_d;
  logic [3:0]                arid_q, arid_d;
  logic [BEAT_CNT_WIDTH-1:0] arlen_q, arlen_d;
  logic [BEAT_CNT_WIDTH-1:0] r_cnt_q, r_cnt_d;
  logic [DEPTH_LOG2-1:0]     r_base_q, r_base_d;
  logic [LAT_CNT_WIDTH-1:0]  lat_q, lat_d;

  logic [DEPTH_LOG2-1:0]     w_idx, r_idx;
  logic                      w_last_beat, r_last_beat;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      unused_addr_bits;

  // Index arithmetic is DEPTH_LOG2 bits wide so bursts wrap at the array end.
  assign w_idx       = w_base_q + DEPTH_LOG2'(w_cnt_q);
  assign r_idx       = r_base_q + DEPTH_LOG2'(r_cnt_q);
  assign w_last_beat = (w_cnt_q == awlen_q);
  assign r_last_beat = (r_cnt_q == arlen_q);

  assign unused_addr_bits = ^{AWADDR[1:0], AWADDR[ADDR_WIDTH-1:DEPTH_LOG2+2],
                              ARADDR[1:0], ARADDR[ADDR_WIDTH-1:DEPTH_LOG2+2]};

  axi_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(w_idx),
    .wdata(WDATA),
    .raddr(r_idx),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      awlen_q   <= '0;
      w_cnt_q   <= '0;
      w_base_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      awlen_q   <= awlen_d;
      w_cnt_q   <= w_cnt_d;
      w_base_q  <= w_base_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    awlen_d   = awlen_q;
    w_cnt_d   = w_cnt_q;
    w_base_d  = w_base_q;
    perr_d    = perr_q;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID) begin
          awid_d    = AWID;
          awlen_d   = AWLEN;
          w_base_d  = AWADDR[DEPTH_LOG2+1:2];
          w_cnt_d   = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID) begin
          // The burst ends on the beat count; WLAST and WID are only policed.
          if ((WLAST != w_last_beat) || (WID != awid_q)) perr_d = 1'b1;
          if (w_last_beat) w_state_d = W_RESP;
          else             w_cnt_d   = w_cnt_q + 1'b1;
        end
      end
      W_RESP: begin
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BID     = '0;
    mem_we  = 1'b0;
    if (!rst) begin
      case (w_state_q)
        W_IDLE: AWREADY = 1'b1;
        W_DATA: begin
          WREADY = 1'b1;
          mem_we = WVALID;
        end
        W_RESP: begin
          BVALID = 1'b1;
          BID    = awid_q;
        end
        default: ;
      endcase
    end
  end

  assign protocol_error = perr_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      arlen_q   <= '0;
      r_cnt_q   <= '0;
      r_base_q  <= '0;
      lat_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      arlen_q   <= arlen_d;
      r_cnt_q   <= r_cnt_d;
      r_base_q  <= r_base_d;
      lat_q     <= lat_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    arlen_d   = arlen_q;
    r_cnt_d   = r_cnt_q;
    r_base_d  = r_base_q;
    lat_d     = lat_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          arid_d    = ARID;
          arlen_d   = ARLEN;
          r_base_d  = ARADDR[DEPTH_LOG2+1:2];
          r_cnt_d   = '0;
          lat_d     = LAT_CNT_WIDTH'(READ_LATENCY);
          r_state_d = (READ_LATENCY == 0) ? R_DATA : R_WAIT;
        end
      end
      R_WAIT: begin
        // Leave as the counter reaches zero so exactly READ_LATENCY cycles are spent here.
        lat_d = lat_q - 1'b1;
        if (lat_q <= LAT_CNT_WIDTH'(1)) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (RREADY) begin
          if (r_last_beat) r_state_d = R_IDLE;
          else             r_cnt_d   = r_cnt_q + 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    RID     = '0;
    RDATA   = '0;
    if (!rst) begin
      case (r_state_q)
        R_IDLE: ARREADY = 1'b1;
        R_DATA: begin
          RVALID = 1'b1;
          RLAST  = r_last_beat;
          RID    = arid_q;
          RDATA  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
